// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell shared by the serial adder datapath.
module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic car_out
);

  assign sum_out = a_in ^ b_in ^ c_in;
  assign car_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full_adder cell, LSB first, registered carry,
// result held with a done/ack handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  input  logic             ack_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             car_out
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               car_q, car_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_sum, fa_car;

  full_adder u_fa (
    .a_in    (opa_q[0]),
    .b_in    (opb_q[0]),
    .c_in    (carry_q),
    .sum_out (fa_sum),
    .car_out (fa_car)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      car_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      car_q   <= car_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    car_d   = car_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          opa_d   = a_in;
          opb_d   = b_in;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_car;
        // Insert the new bit at the MSB via shift/OR so WIDTH=1 needs no reversed slice.
        res_d   = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_d;
          car_d   = fa_car;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_out = (state_q != IDLE);
  assign done_out = (state_q == DONE);
  assign sum_out  = sum_q;
  assign car_out  = car_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances
// against an arithmetic reference model.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, ack8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, car8;
  logic [7:0] sum8;
  logic       start1 = 1'b0, ack1 = 1'b0, c1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, car1;
  logic [0:0] sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start8), .a_in(a8), .b_in(b8),
    .c_in(c8), .busy_out(busy8), .done_out(done8), .ack_in(ack8),
    .sum_out(sum8), .car_out(car8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .a_in(a1), .b_in(b1),
    .c_in(c1), .busy_out(busy1), .done_out(done1), .ack_in(ack1),
    .sum_out(sum1), .car_out(car1)
  );

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return 9'(t % 512);
  endfunction

  // Drive one start pulse; returns at the negedge after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Wait (bounded) for done; cyc counts edges after the start edge, held
  // reports whether the previous result {car,sum} stayed at prev throughout.
  task automatic wait_done8(input logic [8:0] prev, output int cyc, output bit held);
    held = ({car8, sum8} == prev);
    cyc = 0;
    while (!done8 && cyc < 14) begin
      @(negedge clk);
      cyc++;
      if (!done8 && {car8, sum8} != prev) held = 1'b0;
    end
  endtask

  task automatic ack_op8();
    @(negedge clk);
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
  endtask

  logic [8:0] last8 = '0;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, car8, sum8} !== 11'd0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b car=%b sum=%h want all 0", busy8, done8, car8, sum8);
    end
    checks++;
    if ({busy1, done1, car1, sum1} !== 4'd0) begin
      failures++;
      $display("FAIL reset1 got busy=%b done=%b car=%b sum=%b want all 0", busy1, done1, car1, sum1);
    end
    rst_n = 1'b1;
    last8 = '0;
  endtask

  task automatic test_directed();
    logic [7:0] av[3] = '{8'hA5, 8'hFF, 8'hFF};
    logic [7:0] bv[3] = '{8'h5A, 8'h01, 8'hFF};
    logic       cv[3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] want[3] = '{9'h0FF, 9'h100, 9'h1FF};
    int cyc; bit held;
    for (int i = 0; i < 3; i++) begin
      start_op8(av[i], bv[i], cv[i]);
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_busy got busy=%b done=%b want 1/0", i, busy8, done8);
      end
      wait_done8(last8, cyc, held);
      checks++;
      if (cyc != 8) begin
        failures++;
        $display("FAIL dir%0d_latency got %0d cycles want 8", i, cyc);
      end
      checks++;
      if ({car8, sum8} !== want[i]) begin
        failures++;
        $display("FAIL dir%0d_result got car=%b sum=%h want car=%b sum=%h", i, car8, sum8, want[i][8], want[i][7:0]);
      end
      checks++;
      if (!held) begin
        failures++;
        $display("FAIL dir%0d_hold result changed during RUN want %h", i, last8);
      end
      last8 = want[i];
      ack_op8();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_ack got busy=%b done=%b want 0/0", i, busy8, done8);
      end
    end
  endtask

  task automatic test_hold_ack();
    int cyc; bit held;
    logic [8:0] want;
    want = model8(8'h12, 8'h34, 1'b1);
    start_op8(8'h12, 8'h34, 1'b1);
    wait_done8(last8, cyc, held);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (done8 !== 1'b1 || {car8, sum8} !== want) begin
        failures++;
        $display("FAIL hold%0d got done=%b car=%b sum=%h want 1 %h", k, done8, car8, sum8, want);
      end
    end
    last8 = want;
    ack_op8();
    checks++;
    if (done8 !== 1'b0) begin
      failures++;
      $display("FAIL hold_ack got done=%b want 0", done8);
    end
  endtask

  task automatic test_start_ignored();
    int cyc; bit held;
    start_op8(8'h3C, 8'h0F, 1'b0);
    a8 = 8'hF0; b8 = 8'hAA; c8 = 1'b1;
    repeat (3) begin
      @(negedge clk); start8 = ~start8;
      ack8 = start8;
    end
    start8 = 1'b0; ack8 = 1'b0;
    wait_done8(last8, cyc, held);
    checks++;
    if ({car8, sum8} !== 9'h04B || cyc != 5) begin
      failures++;
      $display("FAIL ignore_start got car=%b sum=%h cyc=%0d want 0 4b 5", car8, sum8, cyc);
    end
    last8 = 9'h04B;
    ack_op8();
  endtask

  task automatic test_async_reset();
    int cyc; bit held;
    start_op8(8'h77, 8'h99, 1'b1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, car8, sum8} !== 11'd0) begin
      failures++;
      $display("FAIL async_rst got busy=%b done=%b car=%b sum=%h want all 0", busy8, done8, car8, sum8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL rst_discard got busy=%b done=%b want 0/0", busy8, done8);
    end
    last8 = '0;
    start_op8(8'h01, 8'h01, 1'b1);
    wait_done8(last8, cyc, held);
    checks++;
    if ({car8, sum8} !== 9'h003 || cyc != 8) begin
      failures++;
      $display("FAIL post_rst got car=%b sum=%h cyc=%0d want 0 03 8", car8, sum8, cyc);
    end
    last8 = 9'h003;
    ack_op8();
  endtask

  task automatic test_back_to_back();
    int cyc; bit held;
    start_op8(8'h80, 8'h80, 1'b0);
    wait_done8(last8, cyc, held);
    last8 = model8(8'h80, 8'h80, 1'b0);
    @(negedge clk);
    ack8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || {car8, sum8} !== last8) begin
      failures++;
      $display("FAIL ack_start got busy=%b car=%b sum=%h want 0 %h", busy8, car8, sum8, last8);
    end
  endtask

  task automatic test_random();
    int cyc; bit held;
    logic [7:0] a, b; logic c; logic [8:0] want;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      want = model8(a, b, c);
      start_op8(a, b, c);
      wait_done8(last8, cyc, held);
      checks++;
      if ({car8, sum8} !== want || cyc != 8 || !held) begin
        failures++;
        $display("FAIL rand%0d %h+%h+%b got car=%b sum=%h cyc=%0d held=%b want %h 8 1",
                 i, a, b, c, car8, sum8, cyc, held, want);
      end
      last8 = want;
      ack_op8();
    end
  endtask

  task automatic test_width1();
    int unsigned t;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); c1 = 1'(i); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        failures++;
        $display("FAIL w1_run%0d got busy=%b done=%b want 1/0", i, busy1, done1);
      end
      @(negedge clk);
      t = int'(a1) + int'(b1) + int'(c1);
      checks++;
      if (done1 !== 1'b1 || sum1 !== 1'(t % 2) || car1 !== 1'(t / 2)) begin
        failures++;
        $display("FAIL w1_tt%0d got done=%b sum=%b car=%b want 1 %0d %0d", i, done1, sum1, car1, t % 2, t / 2);
      end
      @(negedge clk); ack1 = 1'b1;
      @(negedge clk); ack1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_ack();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    test_random();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer built around one existing full_adder cell.
- Latches two WIDTH-bit operands plus a carry-in.
- Drives the full_adder one bit per cycle, LSB first, with a registered carry.
- Presents the WIDTH-bit sum and carry-out with a done/ack handshake.
- Sits between a requesting control unit and the shared 1-bit adder datapath, trading latency for area.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, never overridden.

Ports:
clk_in  input  1  system clock, rising edge
rst_n_in  input  1  reset, asynchronous assert, active-low
start_in  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A, captured on accepted start
b_in  input  WIDTH  operand B, captured on accepted start
c_in  input  1  carry-in, captured on accepted start
busy_out  output  1  high in RUN and DONE
done_out  output  1  result valid; held until ack
ack_in  input  1  consumer acknowledge; sampled only in DONE
sum_out  output  WIDTH  registered sum
car_out  output  1  registered carry-out

Behaviour:
- Clock and reset: one clock (clk_in); reset (rst_n_in) is asynchronous and active-low.
- Reset (rst_n_in low, any state, including mid-RUN):
  - state=IDLE; all shift, carry and counter registers = 0.
  - busy_out=0, done_out=0, sum_out=0, car_out=0.
  - Release is synchronous to the next clk_in edge; an in-flight operation is discarded, not resumed.
- IDLE:
  - start_in=1 at an edge: a_in→opa_sr, b_in→opb_sr, c_in→carry_r, cnt=0, go RUN.
  - start_in=0: stay.
- RUN, one bit per cycle:
  - full_adder inputs are opa_sr[0], opb_sr[0], carry_r.
  - Each edge: carry_r←car; res_sr←{sum, res_sr[WIDTH-1:1]}; opa_sr and opb_sr shift right with zero fill; cnt←cnt+1.
  - At the edge where cnt==WIDTH-1: sum_out←final res_sr value including this bit, car_out←car, go DONE.
  - start_in and ack_in are ignored.
- DONE:
  - done_out=1; sum_out and car_out are stable.
  - ack_in=1 at an edge: go IDLE, done_out falls next cycle.
  - start_in in the same cycle as ack_in is ignored; a new request needs start_in in IDLE.
- Latency: the start edge is E0. done_out is first high after edge E0+WIDTH, giving exactly WIDTH cycles of RUN.
- Minimum throughput: one operation per WIDTH+2 cycles.
- sum_out and car_out change only on entry to DONE. Previous results hold through IDLE and RUN.
- Arithmetic: {car_out,sum_out} = a_in + b_in + c_in, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts one cycle; cnt compare against 0.
- busy_out and done_out are decoded directly from state registers, with no combinational path from inputs.

Decomposition:
- Shared package serial_add_pkg holds:
  - state typedef {IDLE=2'b00, RUN=2'b01, DONE=2'b10};
  - constant MAX_WIDTH=32.
- Sub-module: full_adder, the existing cell (a_in, b_in, c_in → sum_out, car_out), instantiated once.
- No other hierarchy. Shift registers, counter and FSM stay in serial_add_ctrl.

Test Plan:
1. WIDTH=8, A=0xA5, B=0x5A, cin=0, start one cycle → busy_out high next cycle; done_out after 8 RUN cycles; sum_out=0xFF, car_out=0.
2. A=0xFF, B=0x01, cin=0 → sum_out=0x00, car_out=1. Then A=0xFF, B=0xFF, cin=1 → sum_out=0xFF, car_out=1.
3. Hold ack_in=0 for 5 cycles in DONE → done_out stays high and outputs stay unchanged. Pulse ack_in → IDLE, done_out=0 next cycle.
4. start_in toggled during RUN with different operands → ignored; result matches the first operands (0x3C+0x0F+0 → 0x4B, car 0).
5. Assert rst_n_in at RUN bit 4 → all outputs 0 immediately (asynchronous). After release, a new 0x01+0x01+1 → 0x03, car 0.
6. WIDTH=1 instance, all 8 input combinations of a, b, c → sum/carry match the full-adder truth table; done after 1 RUN cycle each.
